// File: rtl/ieee_pkg.sv
// Shared IEEE-754 single-precision constants and the controller FSM state type.
package ieee_pkg;

  localparam int FP_EXP_BIAS = 127;
  localparam int FP_MANT_W   = 23;
  localparam int FP_EXP_W    = 8;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE      = 32'h3F80_0000;

  typedef enum logic [2:0] {
    StIdle,
    StConv,
    StStart,
    StWaitCore,
    StPackE,
    StPackS,
    StPackC,
    StDone
  } hyp_state_e;

endpackage

// File: rtl/ieee_hyp_ctrl_if.sv
// Float-domain user handshake of the hyperbolic controller: operand in, three results out.
interface ieee_hyp_ctrl_if;

  logic [31:0] in_x;
  logic        in_stb;
  logic        in_ack;
  logic [31:0] out_epx;
  logic [31:0] out_sinhx;
  logic [31:0] out_coshx;
  logic        out_stb;
  logic        out_ack;
  logic        in_ovf;
  logic        busy;

  modport master (
    output in_x, in_stb, out_ack,
    input  in_ack, out_epx, out_sinhx, out_coshx, out_stb, in_ovf, busy
  );

  modport slave (
    input  in_x, in_stb, out_ack,
    output in_ack, out_epx, out_sinhx, out_coshx, out_stb, in_ovf, busy
  );

endinterface

// File: rtl/fix_to_float.sv
// Combinational signed fixed-point (FRAC fraction bits) to IEEE-754 single conversion,
// round to nearest, ties to even.
module fix_to_float
  import ieee_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input  logic [WIDTH-1:0] fix,
  output logic [31:0]      flt
);

  logic                sign;
  logic [WIDTH:0]      mag;
  logic [5:0]          lead;
  logic [6:0]          sh;
  logic [63:0]         norm;
  logic                round_up;
  logic [FP_MANT_W:0]  mant_r;
  logic [FP_EXP_W-1:0] exp_v;

  always_comb begin
    sign = fix[WIDTH-1];
    // One extra bit so the most negative value has a representable magnitude.
    mag  = sign ? -{fix[WIDTH-1], fix} : {1'b0, fix};

    lead = '0;
    for (int i = 0; i <= int'(WIDTH); i++) begin
      if (mag[i]) lead = 6'(i);
    end

    // Shift the leading one out of the top so the fraction is left-aligned in norm.
    sh       = 7'd64 - {1'b0, lead};
    norm     = 64'(mag) << sh;
    round_up = norm[40] & ((|norm[39:0]) | norm[41]);
    mant_r   = {1'b0, norm[63:41]} + 24'(round_up);
    exp_v    = 8'(int'(lead) - int'(FRAC) + FP_EXP_BIAS) + 8'(mant_r[FP_MANT_W]);

    if (fix == '0) begin
      flt = FP_POS_ZERO;
    end else begin
      flt = {sign, exp_v, mant_r[FP_MANT_W-1:0]};
    end
  end

endmodule

// File: rtl/ieee_hyp_ctrl.sv
// IEEE-754 front/back end for the fixed-point hyperbolic CORDIC core: float-to-fixed on
// entry, one shared fixed-to-float converter time-multiplexed over the three results.
module ieee_hyp_ctrl
  import ieee_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  ieee_hyp_ctrl_if.slave   bus,
  output logic [WIDTH-1:0] core_x,
  output logic             core_en,
  input  logic [WIDTH-1:0] core_epx,
  input  logic [WIDTH-1:0] core_sinhx,
  input  logic [WIDTH-1:0] core_coshx,
  input  logic             core_valid
);

  localparam logic [WIDTH-1:0] FIX_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam int               SHIFT_BASE = int'(FRAC) - FP_EXP_BIAS - FP_MANT_W;

  hyp_state_e       state_q, state_d;
  logic [31:0]      x_q;
  logic [WIDTH-1:0] core_x_q;
  logic             ovf_q;
  logic [WIDTH-1:0] res_e_q, res_s_q, res_c_q;
  logic [31:0]      out_e_q, out_s_q, out_c_q;

  // Float-to-fixed of the latched operand.
  logic [23:0]      mant24;
  logic [63:0]      mag64;
  logic             f2x_ovf;
  logic [WIDTH-1:0] sat_mag;
  logic [WIDTH-1:0] f2x_val;
  int               shamt;
  int               rsh;

  always_comb begin
    mant24  = {1'b1, x_q[22:0]};
    mag64   = '0;
    f2x_ovf = 1'b0;
    shamt   = int'(x_q[30:23]) + SHIFT_BASE;
    rsh     = -shamt;
    if (x_q[30:23] == 8'hFF) begin
      f2x_ovf = 1'b1;
    end else if (x_q[30:23] != 8'h00) begin
      // A leading one at bit 63 or above is far beyond any WIDTH we support.
      if (shamt >= 40) begin
        f2x_ovf = 1'b1;
      end else if (shamt >= 0) begin
        mag64 = 64'(mant24) << shamt[5:0];
      end else if (shamt > -24) begin
        mag64 = 64'(mant24) >> rsh[4:0];
      end
      if (mag64 > 64'(FIX_MAX)) f2x_ovf = 1'b1;
    end
    sat_mag = f2x_ovf ? FIX_MAX : mag64[WIDTH-1:0];
    f2x_val = x_q[31] ? -sat_mag : sat_mag;
  end

  // Shared converter input, selected by the pack phase.
  logic [WIDTH-1:0] conv_in;
  logic [31:0]      conv_out;

  always_comb begin
    conv_in = res_c_q;
    unique case (state_q)
      StPackE: conv_in = res_e_q;
      StPackS: conv_in = res_s_q;
      default: conv_in = res_c_q;
    endcase
  end

  fix_to_float #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_fix_to_float (
    .fix (conv_in),
    .flt (conv_out)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (bus.in_stb) state_d = StConv;
      StConv:     state_d = StStart;
      StStart:    state_d = StWaitCore;
      StWaitCore: if (core_valid) state_d = StPackE;
      StPackE:    state_d = StPackS;
      StPackS:    state_d = StPackC;
      StPackC:    state_d = StDone;
      StDone:     if (bus.out_ack) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      core_x_q <= '0;
      ovf_q    <= 1'b0;
      res_e_q  <= '0;
      res_s_q  <= '0;
      res_c_q  <= '0;
      out_e_q  <= '0;
      out_s_q  <= '0;
      out_c_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.in_stb) x_q <= bus.in_x;
      if (state_q == StConv) begin
        core_x_q <= f2x_val;
        ovf_q    <= f2x_ovf;
      end
      if (state_q == StWaitCore && core_valid) begin
        res_e_q <= core_epx;
        res_s_q <= core_sinhx;
        res_c_q <= core_coshx;
      end
      if (state_q == StPackE) out_e_q <= conv_out;
      if (state_q == StPackS) out_s_q <= conv_out;
      if (state_q == StPackC) out_c_q <= conv_out;
    end
  end

  // in_ack is masked during reset so it reads 0 while rst is held.
  assign bus.in_ack    = (state_q == StIdle) & ~rst;
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_stb   = (state_q == StDone);
  assign bus.in_ovf    = ovf_q;
  assign bus.out_epx   = out_e_q;
  assign bus.out_sinhx = out_s_q;
  assign bus.out_coshx = out_c_q;
  assign core_x        = core_x_q;
  assign core_en       = (state_q == StStart);

endmodule
